barrel_shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one BarrelShift datapath instance between NREQ independent requesters. Each requester presents a data word and a shift amount over a valid/ready handshake. The winner's operands drive the shared shifter, and the result is captured in a one-entry output register tagged with the requester ID. Sits between the requesting units (ALU lanes, packers) and the single shifter resource.

---
 rtl/barrel_shift_arbiter.sv | 136 +++++++++++++
 tb/tb_barrel_shift_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between NREQ requesters, with a
// one-entry tagged result register. Optional grant locking: define BSHIFT_ARB_LOCK_EN.
module barrel_shift_arbiter #(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned LEFT   = 1,
  parameter int unsigned NREQ   = 4,
  localparam int unsigned SW    = $clog2(LENGTH),
  localparam int unsigned IW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*LENGTH-1:0] req_data,
  input  logic [NREQ*SW-1:0]   req_shamt,
`ifdef BSHIFT_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [LENGTH-1:0]    out_data,
  output logic [IW-1:0]        out_id,
  input  logic                 out_ready
);

  logic [IW-1:0]     r_rr_ptr;
  logic              r_out_valid;
  logic [LENGTH-1:0] r_out_data;
  logic [IW-1:0]     r_out_id;

  logic              w_accept;
  logic              w_any;
  logic              w_grant_ok;
  logic              w_xfer;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_grant_idx;
  logic [IW-1:0]     w_next_ptr;
  logic [LENGTH-1:0] w_sel_data;
  logic [SW-1:0]     w_sel_shamt;
  logic [LENGTH-1:0] w_stage [SW+1];

`ifdef BSHIFT_ARB_LOCK_EN
  logic              r_locked;
  logic              w_lock_release;
`endif

  assign w_accept = ~r_out_valid | out_ready;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    w_any       = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % int'(NREQ));
      if (!w_any && req_valid[w_idx]) begin
        w_any       = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

`ifdef BSHIFT_ARB_LOCK_EN
  // While locked rr_ptr names the owner; nobody else may win.
  assign w_grant_ok     = w_any & ~(r_locked & ~req_valid[r_rr_ptr]);
  assign w_lock_release = r_locked & w_accept & ~req_valid[r_rr_ptr];
`else
  assign w_grant_ok = w_any;
`endif

  always_comb begin
    req_ready = '0;
    if (!reset && w_accept && w_grant_ok) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_xfer     = |req_ready;
  assign w_next_ptr = (w_grant_idx == IW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // Without a grant w_grant_idx is zero, so the shifter sees requester 0.
  assign w_sel_data  = req_data[int'(w_grant_idx)*LENGTH +: LENGTH];
  assign w_sel_shamt = req_shamt[int'(w_grant_idx)*SW +: SW];

  assign w_stage[0] = w_sel_data;
  for (genvar b = 0; b < SW; b++) begin : g_stage
    localparam int unsigned Amt = 1 << b;
    if (LEFT != 0) begin : g_left
      assign w_stage[b+1] = w_sel_shamt[b] ? (w_stage[b] << Amt) : w_stage[b];
    end else begin : g_right
      assign w_stage[b+1] = w_sel_shamt[b] ? (w_stage[b] >> Amt) : w_stage[b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
`ifdef BSHIFT_ARB_LOCK_EN
      r_locked    <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_stage[SW];
      r_out_id    <= w_grant_idx;
`ifdef BSHIFT_ARB_LOCK_EN
      if (req_lock[w_grant_idx]) begin
        r_rr_ptr <= w_grant_idx;
        r_locked <= 1'b1;
      end else begin
        r_rr_ptr <= w_next_ptr;
        r_locked <= 1'b0;
      end
`else
      r_rr_ptr    <= w_next_ptr;
`endif
    end else begin
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
`ifdef BSHIFT_ARB_LOCK_EN
      // Owner went idle: drop the lock and resume rotation after it.
      if (w_lock_release) begin
        r_locked <= 1'b0;
        r_rr_ptr <= (r_rr_ptr == IW'(NREQ - 1)) ? '0 : r_rr_ptr + 1'b1;
      end
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Scoreboard bench for barrel_shift_arbiter (LENGTH=8, LEFT=1, NREQ=4), directed vectors.
module tb_barrel_shift_arbiter;
  localparam int NREQ = 4;
  localparam int LEN  = 8;
  localparam int SW   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*LEN-1:0] req_data;
  logic [NREQ*SW-1:0] req_shamt;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [LEN-1:0]    out_data;
  logic [1:0]        out_id;
  logic              out_ready;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb [$];
  logic [9:0] mon_exp;

  always #5 clk = ~clk;

  barrel_shift_arbiter #(.LENGTH(LEN), .LEFT(1), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_shamt (req_shamt),
`ifdef BSHIFT_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic set_op(input int i, input logic [7:0] d, input logic [2:0] s);
    req_data[i*LEN +: LEN] = d;
    req_shamt[i*SW +: SW]  = s;
  endtask

  // Check grants before the edge, queue the expected result, advance one cycle.
  task automatic step(input logic [3:0] exp_rdy, input logic [7:0] exp_data);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0) sb.push_back({oh2idx(exp_rdy), exp_data});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result actual id=%0d data=%h required none", out_id, out_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({out_id, out_data} !== mon_exp) begin
          bad++;
          $display("FAIL result actual id=%0d data=%h required id=%0d data=%h",
                   out_id, out_data, mon_exp[9:8], mon_exp[7:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; req_shamt = '0; req_lock = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_id", 32'(out_id), 32'd0);
    reset = 1'b0;

    // Single request: A5 << 3 = 28
    set_op(0, 8'hA5, 3'd3);
    req_valid = 4'b0001; out_ready = 1'b1;
    step(4'b0001, 8'h28);
    req_valid = '0;
    step(4'b0000, 8'h00);

    // Full round-robin from rr_ptr=0
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    set_op(0, 8'h01, 3'd1); set_op(1, 8'h03, 3'd2);
    set_op(2, 8'h81, 3'd1); set_op(3, 8'h0F, 3'd4);
    req_valid = 4'b1111;
    repeat (2) begin
      step(4'b0001, 8'h02); step(4'b0010, 8'h0C);
      step(4'b0100, 8'h02); step(4'b1000, 8'hF0);
    end

    // Backpressure with requesters 1 and 2 waiting
    set_op(0, 8'hA5, 3'd3);
    req_valid = 4'b0001;
    step(4'b0001, 8'h28);
    req_valid = 4'b0110; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'h28);
      chk("hold_id", 32'(out_id), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    step(4'b0010, 8'h0C);
    req_valid = 4'b0100;
    step(4'b0100, 8'h02);

    // Shift edges, rr_ptr=3 wraps to requester 0
    set_op(0, 8'hFF, 3'd0);
    req_valid = 4'b0001;
    step(4'b0001, 8'hFF);
    set_op(0, 8'hFF, 3'd7);
    step(4'b0001, 8'h80);
    req_valid = '0;
    step(4'b0000, 8'h00);

    // Reset with a held result and rr_ptr=2
    req_valid = 4'b0010; out_ready = 1'b0;
    step(4'b0010, 8'h0C);
    void'(sb.pop_back());
    req_valid = 4'b1111; reset = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_out_data", 32'(out_data), 32'd0);
    chk("rst2_out_id", 32'(out_id), 32'd0);
    out_ready = 1'b1;
    step(4'b0001, 8'h80);
    step(4'b0010, 8'h0C);

`ifdef BSHIFT_ARB_LOCK_EN
    // rr_ptr=2: requester 2 holds the grant while locked
    req_lock = 4'b0100;
    repeat (3) step(4'b0100, 8'h02);
    req_lock = 4'b0000;
    step(4'b0100, 8'h02);
    step(4'b1000, 8'hF0);
`endif

    req_valid = '0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(4'b0000, 8'h00);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
